// File: rtl/upsampler_pkg.sv
// Shared types and constants for the horizontal fp16 zero-insertion upsampler.
package upsampler_pkg;

  localparam int COORD_WIDTH = 16;
  localparam logic [15:0] FP16_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    S_FIRST,
    S_HOLD,
    S_EVEN,
    S_TAIL
  } state_t;

endpackage

// File: rtl/upsampler_h_zero_insert_fp16.sv
// 2x horizontal zero insertion feeding a 1x3 convolution: emits one {left, centre, right}
// window per output column, two per accepted pixel, throttling the input through ready_o.
module upsampler_h_zero_insert_fp16
  import upsampler_pkg::*;
#(
  parameter int EXP_WIDTH    = 5,
  parameter int FRAC_WIDTH   = 10,
  parameter int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH,
  parameter int IMAGE_WIDTH  = 640
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [FP_WIDTH_REG-1:0]            data_i,
  input  logic [COORD_WIDTH-1:0]             col_i,
  input  logic [COORD_WIDTH-1:0]             row_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  output logic [0:2][FP_WIDTH_REG-1:0]       window_o,
  output logic [COORD_WIDTH-1:0]             col_o,
  output logic [COORD_WIDTH-1:0]             row_o,
  output logic                               valid_o
);

  localparam logic [FP_WIDTH_REG-1:0] ZERO_WORD = FP_WIDTH_REG'(FP16_ZERO);
  localparam logic [COORD_WIDTH-1:0]  LAST_K    = COORD_WIDTH'(IMAGE_WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0]  TAIL_COL  = COORD_WIDTH'(2 * IMAGE_WIDTH - 1);

  state_t                          state_q, state_d;
  logic [COORD_WIDTH-1:0]          k_q, k_d;
  logic [FP_WIDTH_REG-1:0]         hold_q, hold_d;
  logic [COORD_WIDTH-1:0]          row_d, col_d;
  logic [0:2][FP_WIDTH_REG-1:0]    win_d;
  logic                            valid_d;
  logic                            accept;
  logic                            start_row;

  assign ready_o = (state_q == S_FIRST) || (state_q == S_HOLD);
  assign accept  = valid_i && ready_o;
  // A col_i==0 pixel arriving mid-row abandons the pending row and restarts at column 0.
  assign start_row = accept && ((state_q == S_FIRST) || (col_i == '0));

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    hold_d  = hold_q;
    row_d   = row_o;
    col_d   = col_o;
    win_d   = window_o;
    valid_d = 1'b0;

    if (start_row) begin
      hold_d  = data_i;
      k_d     = '0;
      row_d   = row_i;
      col_d   = '0;
      win_d   = {ZERO_WORD, data_i, ZERO_WORD};
      valid_d = 1'b1;
      state_d = (IMAGE_WIDTH == 1) ? S_TAIL : S_HOLD;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (accept) begin
            col_d   = {k_q[COORD_WIDTH-2:0], 1'b1};
            win_d   = {hold_q, ZERO_WORD, data_i};
            valid_d = 1'b1;
            hold_d  = data_i;
            k_d     = k_q + COORD_WIDTH'(1);
            state_d = S_EVEN;
          end
        end
        S_EVEN: begin
          col_d   = {k_q[COORD_WIDTH-2:0], 1'b0};
          win_d   = {ZERO_WORD, hold_q, ZERO_WORD};
          valid_d = 1'b1;
          state_d = (k_q == LAST_K) ? S_TAIL : S_HOLD;
        end
        S_TAIL: begin
          // Right boundary replicates the last pixel.
          col_d   = TAIL_COL;
          win_d   = {hold_q, ZERO_WORD, hold_q};
          valid_d = 1'b1;
          state_d = S_FIRST;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_FIRST;
      k_q      <= '0;
      hold_q   <= '0;
      row_o    <= '0;
      col_o    <= '0;
      window_o <= '0;
      valid_o  <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      hold_q   <= hold_d;
      row_o    <= row_d;
      col_o    <= col_d;
      window_o <= win_d;
      valid_o  <= valid_d;
    end
  end

endmodule

// File: tb/tb_upsampler_h_zero_insert_fp16.sv
// Self-checking bench: W=4 and W=1 instances, table-driven rows checked through a scoreboard.
module tb_upsampler_h_zero_insert_fp16;

  typedef struct {
    logic [15:0] col;
    logic [15:0] row;
    logic [47:0] win;
  } sb_t;

  typedef struct {
    logic [15:0] data;
    logic [15:0] col;
    logic [15:0] row;
    int          gap;
  } pix_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // W=4 instance
  logic [15:0] data4 = '0, col4 = '0, row4 = '0;
  logic        valid4 = 1'b0, ready4, vo4;
  logic [47:0] win4;
  logic [15:0] colo4, rowo4;

  // W=1 instance
  logic [15:0] data1 = '0, col1 = '0, row1 = '0;
  logic        valid1 = 1'b0, ready1, vo1;
  logic [47:0] win1;
  logic [15:0] colo1, rowo1;

  upsampler_h_zero_insert_fp16 #(.IMAGE_WIDTH(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .data_i(data4), .col_i(col4), .row_i(row4),
    .valid_i(valid4), .ready_o(ready4), .window_o(win4), .col_o(colo4),
    .row_o(rowo4), .valid_o(vo4)
  );

  upsampler_h_zero_insert_fp16 #(.IMAGE_WIDTH(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .data_i(data1), .col_i(col1), .row_i(row1),
    .valid_i(valid1), .ready_o(ready1), .window_o(win1), .col_o(colo1),
    .row_o(rowo1), .valid_o(vo1)
  );

  int checks = 0;
  int fails  = 0;
  sb_t q4[$];
  sb_t q1[$];

  // Reference model for the W=4 instance, advanced once per accepted pixel.
  localparam int MW = 4;
  int          m_k = 0;
  logic        m_in_row = 1'b0;
  logic [15:0] m_prev = '0;
  logic [15:0] m_row = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void push4(input int c, input logic [15:0] r,
                                input logic [15:0] l, input logic [15:0] m, input logic [15:0] rt);
    sb_t e;
    e.col = 16'(c);
    e.row = r;
    e.win = {l, m, rt};
    q4.push_back(e);
  endfunction

  function automatic void model_accept(input logic [15:0] d, input logic [15:0] c,
                                       input logic [15:0] r);
    if (!m_in_row || c == 16'd0) begin
      m_row = r;
      m_k = 0;
      m_in_row = 1'b1;
      push4(0, m_row, 16'h0000, d, 16'h0000);
    end else begin
      push4(2 * m_k + 1, m_row, m_prev, 16'h0000, d);
      m_k++;
      push4(2 * m_k, m_row, 16'h0000, d, 16'h0000);
    end
    m_prev = d;
    if (m_k == MW - 1) begin
      push4(2 * MW - 1, m_row, d, 16'h0000, d);
      m_in_row = 1'b0;
    end
  endfunction

  always @(negedge clk) begin
    sb_t e;
    if (vo4) begin
      if (q4.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_window_w4: col %0d row %0d win %h", colo4, rowo4, win4);
      end else begin
        e = q4.pop_front();
        check("window_w4", {colo4, rowo4, win4[47:16]}, {e.col, e.row, e.win[47:16]});
        check("window_w4_right", {48'h0, win4[15:0]}, {48'h0, e.win[15:0]});
      end
    end
    if (vo1) begin
      if (q1.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_window_w1: col %0d win %h", colo1, win1);
      end else begin
        e = q1.pop_front();
        check("window_w1", {colo1, win1}, {e.col, e.win});
      end
    end
  end

  task automatic wait_ready4();
    int n = 0;
    while (!ready4 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready4) begin
      checks++;
      fails++;
      $display("FAIL ready_timeout: got ready 0 expected 1 within 20 cycles");
    end
  endtask

  task automatic send4(input pix_t p);
    wait_ready4();
    for (int g = 0; g < p.gap; g++) begin
      @(posedge clk); #1;
      check("gap_valid_low", {63'h0, vo4}, 64'h0);
    end
    data4 = p.data; col4 = p.col; row4 = p.row; valid4 = 1'b1;
    wait_ready4();
    @(posedge clk);
    model_accept(p.data, p.col, p.row);
    #1;
    valid4 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q4.size() != 0 || q1.size() != 0) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_queue_empty", 64'(q4.size() + q1.size()), 64'h0);
  endtask

  pix_t        t_stream[4];
  sb_t         t_exp[8];
  logic        t_ready[8];
  pix_t        t_rows[$];

  initial begin
    // Streaming row, expected windows and ready pattern written out literally.
    t_stream[0] = '{16'h3C00, 16'd0, 16'd3, 0};
    t_stream[1] = '{16'h4000, 16'd1, 16'd3, 0};
    t_stream[2] = '{16'h4200, 16'd2, 16'd3, 0};
    t_stream[3] = '{16'h4400, 16'd3, 16'd3, 0};
    t_exp[0] = '{16'd0, 16'd3, {16'h0000, 16'h3C00, 16'h0000}};
    t_exp[1] = '{16'd1, 16'd3, {16'h3C00, 16'h0000, 16'h4000}};
    t_exp[2] = '{16'd2, 16'd3, {16'h0000, 16'h4000, 16'h0000}};
    t_exp[3] = '{16'd3, 16'd3, {16'h4000, 16'h0000, 16'h4200}};
    t_exp[4] = '{16'd4, 16'd3, {16'h0000, 16'h4200, 16'h0000}};
    t_exp[5] = '{16'd5, 16'd3, {16'h4200, 16'h0000, 16'h4400}};
    t_exp[6] = '{16'd6, 16'd3, {16'h0000, 16'h4400, 16'h0000}};
    t_exp[7] = '{16'd7, 16'd3, {16'h4400, 16'h0000, 16'h4400}};
    t_ready  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_valid_w4", {63'h0, vo4}, 64'h0);
    check("reset_ready_w4", {63'h0, ready4}, 64'h1);
    check("reset_outputs_w4", {win4, colo4}, 64'h0);
    check("reset_row_w4", {48'h0, rowo4}, 64'h0);
    check("reset_state_w1", {62'h0, vo1, ready1}, 64'h1);

    // Test 1: W=4 streamed with valid held high
    foreach (t_exp[i]) q4.push_back(t_exp[i]);
    begin
      int idx = 0;
      for (int cyc = 0; cyc < 8; cyc++) begin
        valid4 = (idx < 4);
        if (idx < 4) begin
          data4 = t_stream[idx].data; col4 = t_stream[idx].col; row4 = t_stream[idx].row;
        end
        check($sformatf("stream_ready_%0d", cyc), {63'h0, ready4}, {63'h0, t_ready[cyc]});
        @(posedge clk);
        if (valid4 && ready4) idx++;
        #1;
      end
      valid4 = 1'b0;
    end
    drain();
    check("stream_back_to_first", {63'h0, ready4}, 64'h1);

    // Test 2: W=1
    q1.push_back('{16'd0, 16'd2, {16'h0000, 16'h3C00, 16'h0000}});
    q1.push_back('{16'd1, 16'd2, {16'h3C00, 16'h0000, 16'h3C00}});
    data1 = 16'h3C00; col1 = 16'd0; row1 = 16'd2; valid1 = 1'b1;
    @(posedge clk); #1;
    valid1 = 1'b0;
    check("w1_ready_in_tail", {63'h0, ready1}, 64'h0);
    drain();
    check("w1_ready_after_row", {63'h0, ready1}, 64'h1);
    check("w1_row_latched", {48'h0, rowo1}, 64'd2);

    // Test 3: 3-cycle gap before x[2], then passthrough of special words
    t_rows = '{
      '{16'h3C00, 16'd0, 16'd4, 0}, '{16'h4000, 16'd1, 16'd4, 0},
      '{16'h4200, 16'd2, 16'd4, 3}, '{16'h4400, 16'd3, 16'd4, 0},
      '{16'h7E00, 16'd0, 16'd7, 0}, '{16'h8000, 16'd1, 16'd7, 0},
      '{16'hFC00, 16'd2, 16'd7, 1}, '{16'h0001, 16'd3, 16'd7, 0}
    };
    foreach (t_rows[i]) send4(t_rows[i]);
    drain();

    // Test 4: resync mid-row, row 5 abandoned after x1, row 6 restarts at col 0
    t_rows = '{
      '{16'h3C00, 16'd0, 16'd5, 0}, '{16'h4000, 16'd1, 16'd5, 0},
      '{16'h4800, 16'd0, 16'd6, 0}, '{16'h4A00, 16'd1, 16'd6, 0},
      '{16'h4C00, 16'd2, 16'd6, 0}, '{16'h4E00, 16'd3, 16'd6, 0}
    };
    foreach (t_rows[i]) send4(t_rows[i]);
    drain();
    check("resync_row_latched", {48'h0, rowo4}, 64'd6);

    // Test 5: reset while in S_EVEN, then a fresh row from col 0
    send4('{16'h3C00, 16'd0, 16'd8, 0});
    send4('{16'h4000, 16'd1, 16'd8, 0});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrow_reset_valid", {63'h0, vo4}, 64'h0);
    check("midrow_reset_ready", {63'h0, ready4}, 64'h1);
    check("midrow_reset_window", {16'h0, win4}, 64'h0);
    q4.delete();
    m_in_row = 1'b0;
    m_k = 0;
    t_rows = '{
      '{16'h5000, 16'd0, 16'd9, 0}, '{16'h5100, 16'd1, 16'd9, 0},
      '{16'h5200, 16'd2, 16'd9, 0}, '{16'h5300, 16'd3, 16'd9, 0}
    };
    foreach (t_rows[i]) send4(t_rows[i]);
    drain();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
